// File: rtl/uart_tx_core_if.sv
// Host-side request/handshake bundle for uart_tx_core: byte, frame config,
// send/ready handshake and the per-frame done pulse.
interface uart_tx_core_if;
  logic [7:0] data_in;
  logic       send;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic       ready;
  logic       done;

  modport master (
    output data_in, send, data_size, parity_en, parity_mode, stop_bit_size,
    input  ready, done
  );

  modport slave (
    input  data_in, send, data_size, parity_en, parity_mode, stop_bit_size,
    output ready, done
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: 7/8 data bits, optional odd/even/mark/space parity, 1/2 stop bits,
// internal baud divider. Define UART_TX_BUFFER_EN to add a one-entry request holding register.
module uart_tx_core #(
  parameter int CLK_DIV = 868,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_core_if.slave host,
  output logic          tx
);

  typedef enum logic [2:0] {S_READY, S_START, S_DATA, S_PARITY, S_END} state_e;

  typedef struct packed {
    logic       size8;
    logic       pen;
    logic [1:0] pmode;
    logic       stop2;
  } cfg_t;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  cfg_t             cfg_q, cfg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic       bit_tick, frame_end, accept, launch;
  logic [7:0] launch_data, launch_masked;
  cfg_t       launch_cfg, in_cfg;

  assign in_cfg    = {host.data_size, host.parity_en, host.parity_mode, host.stop_bit_size};
  assign accept    = host.send & ready_q;
  assign bit_tick  = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign frame_end = (state_q == S_END) & bit_tick & (bit_q == {2'b00, cfg_q.stop2});

`ifdef UART_TX_BUFFER_EN
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q;
  cfg_t       hold_cfg_q;
  logic       slot_free;

  // A frame may start when idle or on the very edge the current one finishes.
  assign slot_free    = (state_q == S_READY) | frame_end;
  assign launch       = slot_free & (hold_valid_q | accept);
  assign launch_data  = hold_valid_q ? hold_data_q : host.data_in;
  assign launch_cfg   = hold_valid_q ? hold_cfg_q  : in_cfg;
  assign hold_valid_d = hold_valid_q ? ~slot_free : (accept & ~slot_free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_cfg_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (accept & ~slot_free) begin
        hold_data_q <= host.data_in;
        hold_cfg_q  <= in_cfg;
      end
    end
  end
`else
  assign launch      = accept;
  assign launch_data = host.data_in;
  assign launch_cfg  = in_cfg;
`endif

  assign launch_masked = launch_cfg.size8 ? launch_data : {1'b0, launch_data[6:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_READY;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_READY || bit_tick) ? '0 : cnt_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    case (state_q)
      S_START: if (bit_tick) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == (cfg_q.size8 ? 3'd7 : 3'd6)) begin
          state_d = cfg_q.pen ? S_PARITY : S_END;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_PARITY: if (bit_tick) state_d = S_END;
      S_END: if (bit_tick) begin
        if (frame_end) state_d = S_READY;
        else           bit_d   = bit_q + 3'd1;
      end
      default: ;
    endcase
    if (launch) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = launch_masked;
      cfg_d   = launch_cfg;
      par_d   = launch_cfg.pmode[0] ^ (launch_cfg.pmode[1] & ^launch_masked);
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
`ifdef UART_TX_BUFFER_EN
    ready_d = ~hold_valid_d;
`else
    ready_d = (state_d == S_READY);
`endif
    done_d = frame_end;
  end

  assign tx         = tx_q;
  assign host.ready = ready_q;
  assign host.done  = done_q;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Single-clock UART transmitter. It serialises one byte per request onto a TX line.
- Frame options match the team's UART receiver: 7/8 data bits, optional parity (odd, even, mark or space), and 1 or 2 stop bits.
- It has an internal baud-tick divider, so it needs no external UART clock.
- It sits between a host-side valid/ready producer and the top-level tx pin.

Parameters:
- CLK_DIV, 868, system clock cycles per bit period (100 MHz / 115200). Legal range is 2 or more.
- DIV_W, $clog2(CLK_DIV), width of the baud counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- data_in  input  8  byte to send. In 7-bit mode only bits [6:0] are sent.
- send  input  1  request strobe. Accepted when send & ready are both high at a clk edge.
- data_size  input  1  0: 7-bit; 1: 8-bit.
- parity_en  input  1  1: insert parity bit.
- parity_mode  input  2  11 odd, 10 even, 01 mark (1), 00 space (0).
- stop_bit_size  input  1  0: 1 stop bit; 1: 2 stop bits.
- tx  output  1  serial line, idles high.
- ready  output  1  high when a new request can be accepted.
- done  output  1  one-cycle pulse when the final stop bit ends.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to READY; tx=1, ready=1, done=0.
  - Baud counter, bit counter and shift register are cleared.
  - Reset asserted mid-frame aborts the frame immediately and tx returns high with no glitch low.
- Acceptance: on a clk edge with send & ready, the block latches data_in, data_size, parity_en, parity_mode and stop_bit_size.
  - Changes to these inputs after acceptance do not affect the frame in flight.
  - ready drops on the next cycle.
  - tx goes low on the next cycle (1-cycle latency to start bit).
- Bit period:
  - Every bit lasts exactly CLK_DIV clk cycles.
  - The baud counter restarts at 0 on acceptance and at every bit boundary.
  - The bit boundary is count == CLK_DIV-1.
- State machine, with tx value in each state:
  - READY (tx=1): goes to START on acceptance.
  - START (tx=0): lasts 1 bit, then DATA.
  - DATA (tx=shift[0], LSB first): 7 or 8 bits per data_size.
    - After the last bit: go to PARITY if parity_en, else END.
  - PARITY (tx=parity bit): lasts 1 bit, then END.
  - END (tx=1): lasts 1 or 2 bits per stop_bit_size, then READY.
- Parity bit:
  - Parity is computed over the sent data bits only (7 or 8).
  - Odd: ~^data. Even: ^data. Mark: 1. Space: 0.
  - Equivalent form: parity_mode[0] XOR (parity_mode[1] & ^data).
- Completion:
  - done pulses high for exactly 1 cycle on the cycle after the last stop-bit period ends.
  - ready returns high in that same cycle.
  - A send held high then starts the next frame immediately, giving zero idle bits between frames.
- send while ready=0 is ignored (no queuing unless the optional feature is enabled).
- Frame lengths, in bit periods:
  - Minimum: 1+7+0+1 = 9.
  - Maximum: 1+8+1+2 = 12.
- Outputs tx, ready and done are registered; there is no combinational path from the inputs.

Optional Feature:
- Macro: UART_TX_BUFFER_EN.
- When defined, a one-entry holding register is added.
  - ready = holding register empty, so ready stays high during the first frame.
  - A request accepted while a frame is active is stored together with its config.
  - The stored request is loaded at the same edge the current frame's last stop bit ends, so the next start bit follows with no idle gap.
  - done still pulses once per completed frame.
  - ready goes low only while the holding register is full.
- When undefined, there is no holding register, ready = (state == READY), and behaviour is exactly as described above.

Test Plan:
- Reset and idle: CLK_DIV=4, rst low then high → tx=1, ready=1, done=0; no tx transitions for 100 cycles.
- 8N1 frame: data_in=8'hA5, 8-bit, parity off, 1 stop → tx sequence 0,1,0,1,0,0,1,0,1,1; each bit exactly 4 cycles; done pulses at cycle 41 after acceptance; ready high with it.
- 7O2 frame: data_in=8'hC3 (bits [6:0]=7'h43), 7-bit, odd, 2 stop → 0,1,1,0,0,0,0,1,0,1,1. The parity bit is 0 because the data already has an odd count of three ones.
- Mark/space/even sweep: data 8'h01 8-bit, modes 10/01/00 → parity bits 1/1/0; the receiver model reports error_parity=0 and error_frame=0.
- Back-to-back and ignore:
  - Hold send high with 8'h55 then 8'hAA → second start bit immediately follows the first stop bit.
  - A pulse of send while ready=0 (buffer off) → ignored; no third frame.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 asynchronously; after release, a new 8'h0F request transmits a correct full frame.
